// File: rtl/spi_host_seq.sv
// spi_host_seq: command sequencer that sits in front of the SPI master driver.
// Host commands are queued in a DEPTH-entry FIFO. They are issued one at a
// time with the driver's hold-until-ready-falls handshake. Each masked MISO
// result comes back tagged on a single-entry valid/ready response stage.
// Optional build macro: SPI_SEQ_TIMEOUT_EN enables a START/BUSY watchdog of
// TIMEOUT_CYCLES clocks.
module spi_host_seq #(
  parameter int SPI_MAXLEN     = 32,
  parameter int DEPTH          = 4,
  parameter int TAG_W          = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [$clog2(SPI_MAXLEN):0]     cmd_n_clks,
  input  logic [SPI_MAXLEN-1:0]           cmd_data,
  input  logic [TAG_W-1:0]                cmd_tag,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [SPI_MAXLEN-1:0]           rsp_data,
  output logic [TAG_W-1:0]                rsp_tag,
  output logic                            rsp_err,
  output logic                            start_cmd,
  output logic [$clog2(SPI_MAXLEN):0]     n_clks,
  output logic [SPI_MAXLEN-1:0]           tx_data,
  input  logic                            spi_drv_rdy,
  input  logic [SPI_MAXLEN-1:0]           rx_miso
);

  localparam int NW = $clog2(SPI_MAXLEN) + 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [NW-1:0] MAXLEN_N = NW'(SPI_MAXLEN);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, BUSY, RESP} state_t;

  // Low-n ones mask, built bit by bit so n == SPI_MAXLEN never overflows a shift
  function automatic logic [SPI_MAXLEN-1:0] len_mask(input logic [NW-1:0] n);
    logic [SPI_MAXLEN-1:0] m;
    for (int i = 0; i < SPI_MAXLEN; i++) begin
      m[i] = (i < int'(n));
    end
    return m;
  endfunction

  state_t state, state_nxt;

  logic [NW-1:0]         fifo_n [DEPTH];
  logic [SPI_MAXLEN-1:0] fifo_d [DEPTH];
  logic [TAG_W-1:0]      fifo_t [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic                  fifo_empty;
  logic                  push, pop;

  logic [NW-1:0]         head_n;
  logic [SPI_MAXLEN-1:0] head_d;
  logic [TAG_W-1:0]      head_t;
  logic                  head_bad;

  logic [TAG_W-1:0]      tag_r;
  logic                  go_start, go_bad, go_done, go_tmo;
  logic                  tmo_hit;

  assign cmd_ready  = !reset && (count < DEPTH_C);
  assign fifo_empty = (count == '0);
  assign push       = cmd_valid && cmd_ready;
  assign pop        = go_start || go_bad;

  assign head_n   = fifo_n[rd_ptr];
  assign head_d   = fifo_d[rd_ptr];
  assign head_t   = fifo_t[rd_ptr];
  assign head_bad = (head_n == '0) || (head_n > MAXLEN_N);

  // FIFO storage: payload only, no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_n[wr_ptr] <= cmd_n_clks;
      fifo_d[wr_ptr] <= cmd_data;
      fifo_t[wr_ptr] <= cmd_tag;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef SPI_SEQ_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  // Watchdog: restarts on every state change, counts only while waiting on the driver
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (state_nxt != state) begin
      tmo_cnt <= '0;
    end else if (state == START || state == BUSY) begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end
  end

  assign tmo_hit = (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  // No watchdog in this build: the driver is waited on indefinitely
  assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state plus one-cycle strobes that steer the datapath loads
  always_comb begin
    state_nxt = state;
    go_start  = 1'b0;
    go_bad    = 1'b0;
    go_done   = 1'b0;
    go_tmo    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          if (head_bad) begin
            go_bad    = 1'b1;
            state_nxt = RESP;
          end else if (spi_drv_rdy) begin
            go_start  = 1'b1;
            state_nxt = START;
          end
        end
      end
      START: begin
        if (!spi_drv_rdy) begin
          state_nxt = BUSY;
        end else if (tmo_hit) begin
          go_tmo    = 1'b1;
          state_nxt = RESP;
        end
      end
      BUSY: begin
        if (spi_drv_rdy) begin
          go_done   = 1'b1;
          state_nxt = RESP;
        end else if (tmo_hit) begin
          go_tmo    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs decoded from the registered state, forced low during reset
  always_comb begin
    start_cmd = !reset && (state == START);
    rsp_valid = !reset && (state == RESP);
  end

  // Command and response registers; held stable between the strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      n_clks   <= '0;
      tx_data  <= '0;
      tag_r    <= '0;
      rsp_data <= '0;
      rsp_tag  <= '0;
      rsp_err  <= 1'b0;
    end else begin
      if (go_start) begin
        n_clks  <= head_n;
        tx_data <= head_d;
        tag_r   <= head_t;
      end
      if (go_bad) begin
        rsp_data <= '0;
        rsp_tag  <= head_t;
        rsp_err  <= 1'b1;
      end
      if (go_done) begin
        rsp_data <= rx_miso & len_mask(n_clks);
        rsp_tag  <= tag_r;
        rsp_err  <= 1'b0;
      end
      if (go_tmo) begin
        rsp_data <= '0;
        rsp_tag  <= tag_r;
        rsp_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_host_seq.sv
// tb_spi_host_seq: directed bench for spi_host_seq with a behavioural SPI
// driver model (rdy falls two cycles after start_cmd, MISO returns MOSI
// optionally XORed with a pattern). Timeout test only with SPI_SEQ_TIMEOUT_EN.
module tb_spi_host_seq;

  localparam int ML    = 32;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int NW    = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [NW-1:0]    cmd_n_clks;
  logic [ML-1:0]    cmd_data;
  logic [TAG_W-1:0] cmd_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [ML-1:0]    rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic             start_cmd;
  logic [NW-1:0]    n_clks;
  logic [ML-1:0]    tx_data;
  logic             spi_drv_rdy;
  logic [ML-1:0]    rx_miso;

  always #5 clk = ~clk;

  spi_host_seq #(
    .SPI_MAXLEN(ML), .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_n_clks(cmd_n_clks),
    .cmd_data(cmd_data), .cmd_tag(cmd_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .start_cmd(start_cmd), .n_clks(n_clks), .tx_data(tx_data),
    .spi_drv_rdy(spi_drv_rdy), .rx_miso(rx_miso)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("FAIL %s: event did not occur within the cycle bound", name);
  endtask

  // Driver model
  logic          drv_hold   = 1'b0;
  logic          drv_ignore = 1'b0;
  logic          drv_rdy_m;
  logic [ML-1:0] drv_xor    = '0;
  logic [ML-1:0] drv_cap;
  int            drv_hcnt, drv_bcnt;
  bit            drv_busy;

  assign spi_drv_rdy = drv_hold ? 1'b0 : drv_rdy_m;

  initial begin
    drv_rdy_m = 1'b1;
    rx_miso   = '0;
    drv_cap   = '0;
    drv_busy  = 1'b0;
    drv_hcnt  = 0;
    drv_bcnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (drv_busy) begin
        if (drv_bcnt > 0) begin
          drv_bcnt--;
        end else begin
          rx_miso   = drv_cap ^ drv_xor;
          drv_rdy_m = 1'b1;
          drv_busy  = 1'b0;
        end
      end else if (start_cmd && spi_drv_rdy && !drv_ignore) begin
        drv_hcnt++;
        if (drv_hcnt >= 2) begin
          drv_cap   = tx_data;
          drv_rdy_m = 1'b0;
          drv_busy  = 1'b1;
          drv_bcnt  = 4;
          drv_hcnt  = 0;
        end
      end else begin
        drv_hcnt = 0;
      end
    end
  end

  // Count start_cmd rising edges
  logic start_q = 1'b0;
  int   start_rises = 0;
  always @(posedge clk) begin
    start_q <= start_cmd;
    if (start_cmd && !start_q) start_rises <= start_rises + 1;
  end

  task automatic push(input logic [NW-1:0] n, input logic [ML-1:0] d, input logic [TAG_W-1:0] t);
    int w;
    w = 0;
    cmd_valid  = 1'b1;
    cmd_n_clks = n;
    cmd_data   = d;
    cmd_tag    = t;
    while (!cmd_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) timeout_fail("push_ready");
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input logic [ML-1:0] ed, input logic [TAG_W-1:0] et,
                         input logic ee, input string name);
    int w;
    w = 0;
    while (!rsp_valid && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (!rsp_valid) begin
      timeout_fail({name, "_valid"});
    end else begin
      check({name, "_data"}, rsp_data, ed);
      check({name, "_tag"}, rsp_tag, et);
      check({name, "_err"}, rsp_err, ee);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [NW-1:0]    n;
    logic [ML-1:0]    d;
    logic [TAG_W-1:0] t;
    logic [ML-1:0]    x;
    logic [ML-1:0]    ed;
    logic             ee;
  } vec_t;

  vec_t vt[9];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int r0, bad, w, hi;

    vt[0] = '{6'd32, 32'hFFFFFFFF, 4'd5,  32'h0,        32'hFFFFFFFF, 1'b0};
    vt[1] = '{6'd0,  32'h12345678, 4'd6,  32'h0,        32'h00000000, 1'b1};
    vt[2] = '{6'd33, 32'hFFFFFFFF, 4'd7,  32'h0,        32'h00000000, 1'b1};
    vt[3] = '{6'd8,  32'hFFFFFFA5, 4'd8,  32'h0,        32'h000000A5, 1'b0};
    vt[4] = '{6'd1,  32'h00000003, 4'd9,  32'h0,        32'h00000001, 1'b0};
    vt[5] = '{6'd31, 32'hFFFFFFFF, 4'd10, 32'h0,        32'h7FFFFFFF, 1'b0};
    vt[6] = '{6'd16, 32'hDEADBEEF, 4'd11, 32'h0000FFFF, 32'h00004110, 1'b0};
    vt[7] = '{6'd63, 32'h0000000F, 4'd12, 32'h0,        32'h00000000, 1'b1};
    vt[8] = '{6'd32, 32'h0F0F0F0F, 4'd13, 32'hFFFFFFFF, 32'hF0F0F0F0, 1'b0};

    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_n_clks = '0;
    cmd_data   = '0;
    cmd_tag    = '0;
    rsp_ready  = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_start", start_cmd, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_tag", rsp_tag, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_n_clks", n_clks, 0);
    check("rst_tx_data", tx_data, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);

    // Single command: latency and hold-until-rdy-falls
    push(6'd8, 32'h000000A5, 4'd3);
    check("t1_lat_t1", start_cmd, 0);
    @(negedge clk);
    check("t1_lat_t2", start_cmd, 1);
    @(negedge clk);
    check("t1_hold", start_cmd, 1);
    check("t1_n_clks", n_clks, 8);
    check("t1_tx_data", tx_data, 32'hA5);
    @(negedge clk);
    check("t1_start_drop", start_cmd, 0);
    get_rsp(32'h000000A5, 4'd3, 1'b0, "t1");

    // Fill the FIFO while the driver is not ready
    drv_hold = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) push(6'd8, 32'h10 + i, 4'(i));
    check("t2_not_full", cmd_ready, 1);
    push(6'd8, 32'h13, 4'd3);
    check("t2_full", cmd_ready, 0);
    cmd_valid  = 1'b1;
    cmd_n_clks = 6'd8;
    cmd_data   = 32'h14;
    cmd_tag    = 4'd4;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (cmd_ready) bad++;
    end
    check("t2_full_hold", bad, 0);
    drv_hold = 1'b0;
    @(negedge clk);
    check("t2_pop_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) get_rsp(32'h10 + i, 4'(i), 1'b0, $sformatf("t2_rsp%0d", i));

    // Table of lengths, masks and illegal lengths
    for (int k = 0; k < 9; k++) begin
      drv_xor = vt[k].x;
      r0 = start_rises;
      push(vt[k].n, vt[k].d, vt[k].t);
      get_rsp(vt[k].ed, vt[k].t, vt[k].ee, $sformatf("vec%0d", k));
      check($sformatf("vec%0d_starts", k), start_rises - r0, vt[k].ee ? 0 : 1);
    end
    drv_xor = '0;

    // Response backpressure stalls the next issue
    push(6'd8, 32'h11, 4'd1);
    push(6'd8, 32'h22, 4'd2);
    w = 0;
    while (!rsp_valid && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (!rsp_valid) timeout_fail("t4_first_valid");
    check("t4_first_data", rsp_data, 32'h11);
    check("t4_first_tag", rsp_tag, 1);
    r0 = start_rises;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== 32'h11 || rsp_tag !== 4'd1 || rsp_err !== 1'b0 || start_cmd) bad++;
    end
    check("t4_stable", bad, 0);
    check("t4_no_issue", start_rises - r0, 0);
    check("t4_fifo_accepts", cmd_ready, 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    get_rsp(32'h22, 4'd2, 1'b0, "t4_second");

    // Reset while BUSY with one more command queued
    push(6'd8, 32'h33, 4'd5);
    push(6'd8, 32'h44, 4'd6);
    w = 0;
    while (!start_cmd && w < 200) begin
      @(negedge clk);
      w++;
    end
    w = 0;
    while (start_cmd && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (start_cmd) timeout_fail("t5_reach_busy");
    reset = 1'b1;
    @(negedge clk);
    check("t5_start", start_cmd, 0);
    check("t5_rsp_valid", rsp_valid, 0);
    check("t5_cmd_ready", cmd_ready, 0);
    check("t5_rsp_data", rsp_data, 0);
    check("t5_tx_data", tx_data, 0);
    check("t5_n_clks", n_clks, 0);
    reset = 1'b0;
    @(negedge clk);
    check("t5_cmd_ready_after", cmd_ready, 1);
    r0 = start_rises;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid || start_cmd) bad++;
    end
    check("t5_fifo_empty", bad, 0);
    check("t5_no_starts", start_rises - r0, 0);
    push(6'd4, 32'h0000000F, 4'd7);
    get_rsp(32'h0000000F, 4'd7, 1'b0, "t5_after");

`ifdef SPI_SEQ_TIMEOUT_EN
    // Driver never drops rdy: watchdog ends the command
    drv_ignore = 1'b1;
    push(6'd8, 32'h55, 4'd9);
    w = 0;
    while (!start_cmd && w < 200) begin
      @(negedge clk);
      w++;
    end
    hi = 0;
    while (start_cmd && hi < 1000) begin
      hi++;
      @(negedge clk);
    end
    check("t6_start_cycles", hi, 100);
    check("t6_rsp_valid", rsp_valid, 1);
    get_rsp(32'h0, 4'd9, 1'b1, "t6_tmo");
    drv_ignore = 1'b0;
    push(6'd8, 32'h66, 4'd10);
    get_rsp(32'h66, 4'd10, 1'b0, "t6_next");
`else
    hi = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
